// File: rtl/bldc_deadtime_if.sv
// Gate-drive conditioning bus: run/phase commands in, complementary gate drives and status out.
interface bldc_deadtime_if;
  logic enable;
  logic u_in;
  logic v_in;
  logic w_in;
  logic fault;
  logic clear;
  logic u_hi;
  logic u_lo;
  logic v_hi;
  logic v_lo;
  logic w_hi;
  logic w_lo;
  logic fault_latched;
  logic active;

  modport master (
    output enable, u_in, v_in, w_in, fault, clear,
    input  u_hi, u_lo, v_hi, v_lo, w_hi, w_lo, fault_latched, active
  );

  modport slave (
    input  enable, u_in, v_in, w_in, fault, clear,
    output u_hi, u_lo, v_hi, v_lo, w_hi, w_lo, fault_latched, active
  );
endinterface

// File: rtl/bldc_deadtime.sv
// Complementary gate driver with per-phase dead time, latched fault shutdown and enable gating.
// High and low switches of a phase are never driven together.
module bldc_deadtime #(
  parameter int DEADTIME = 50,
  parameter int CNT_BITS = 16
) (
  input logic           clk,
  input logic           rst,
  bldc_deadtime_if.slave bus
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_DEAD = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  // A zero dead time would never leave DEAD, so it collapses to one cycle.
  localparam logic [CNT_BITS-1:0] DT_LOAD = (DEADTIME == 0) ? CNT_BITS'(1) : CNT_BITS'(DEADTIME);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic                enable_r;
  logic [2:0]          in_r;
  logic                fault_r;
  logic                clear_r;
  logic                fault_latched;
  logic                active;
  logic                run;

  logic [1:0]          state     [3];
  logic [1:0]          state_nxt [3];
  logic [CNT_BITS-1:0] cnt       [3];
  logic [CNT_BITS-1:0] cnt_nxt   [3];
  logic [2:0]          target;
  logic [2:0]          target_nxt;
  logic [2:0]          hi;
  logic [2:0]          hi_nxt;
  logic [2:0]          lo;
  logic [2:0]          lo_nxt;

  // NOTE: every register uses <= so all flops sample pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_r <= 1'b0;
      in_r     <= 3'b000;
      fault_r  <= 1'b0;
      clear_r  <= 1'b0;
    end else begin
      enable_r <= bus.enable;
      in_r     <= {bus.w_in, bus.v_in, bus.u_in};
      fault_r  <= bus.fault;
      clear_r  <= bus.clear;
    end
  end

  // Set has priority over clear so a persisting fault can never be cleared away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_latched <= 1'b0;
    end else if (fault_r) begin
      fault_latched <= 1'b1;
    end else if (clear_r) begin
      fault_latched <= 1'b0;
    end
  end

  assign run = enable_r & ~fault_latched;

  // NOTE: every next-state variable gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      state_nxt[p]  = state[p];
      cnt_nxt[p]    = cnt[p];
      target_nxt[p] = target[p];
      hi_nxt[p]     = 1'b0;
      lo_nxt[p]     = 1'b0;
      if (!run) begin
        state_nxt[p] = ST_OFF;
      end else begin
        case (state[p])
          ST_OFF: begin
            state_nxt[p]  = ST_DEAD;
            target_nxt[p] = in_r[p];
            cnt_nxt[p]    = DT_LOAD;
          end
          ST_DEAD: begin
            if (in_r[p] != target[p]) begin
              target_nxt[p] = in_r[p];
              cnt_nxt[p]    = DT_LOAD;
            end else if (cnt[p] == CNT_ONE) begin
              state_nxt[p] = target[p] ? ST_HIGH : ST_LOW;
              hi_nxt[p]    = target[p];
              lo_nxt[p]    = ~target[p];
            end else begin
              cnt_nxt[p] = cnt[p] - CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (!in_r[p]) begin
              state_nxt[p]  = ST_DEAD;
              target_nxt[p] = 1'b0;
              cnt_nxt[p]    = DT_LOAD;
            end else begin
              hi_nxt[p] = 1'b1;
            end
          end
          ST_LOW: begin
            if (in_r[p]) begin
              state_nxt[p]  = ST_DEAD;
              target_nxt[p] = 1'b1;
              cnt_nxt[p]    = DT_LOAD;
            end else begin
              lo_nxt[p] = 1'b1;
            end
          end
          default: state_nxt[p] = ST_OFF;
        endcase
      end
    end
  end

  // Gate drives are dedicated flops loaded with the transition, never decoded from state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= '{default: ST_OFF};
      cnt    <= '{default: '0};
      target <= 3'b000;
      hi     <= 3'b000;
      lo     <= 3'b000;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      target <= target_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      active <= |(hi_nxt | lo_nxt);
    end
  end

  assign bus.u_hi          = hi[0];
  assign bus.u_lo          = lo[0];
  assign bus.v_hi          = hi[1];
  assign bus.v_lo          = lo[1];
  assign bus.w_hi          = hi[2];
  assign bus.w_lo          = lo[2];
  assign bus.fault_latched = fault_latched;
  assign bus.active        = active;

endmodule

// File: tb/tb_bldc_deadtime.sv
// Bench for bldc_deadtime: timed scoreboard on a DEADTIME=4 instance, random stress on a DEADTIME=0 instance.
module tb_bldc_deadtime;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] mask;
    logic [7:0] val;
  } exp_t;

  // Observation vector: {active, fault_latched, u_hi, u_lo, v_hi, v_lo, w_hi, w_lo}
  localparam logic [7:0] M_ALL  = 8'hFF;
  localparam logic [7:0] M_U    = 8'b0011_0000;
  localparam logic [7:0] M_U_AC = 8'b1011_0000;

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  bldc_deadtime_if a ();
  bldc_deadtime_if b ();

  bldc_deadtime #(.DEADTIME(4), .CNT_BITS(16)) dut_a (.clk(clk), .rst(rst), .bus(a));
  bldc_deadtime #(.DEADTIME(0), .CNT_BITS(8))  dut_b (.clk(clk), .rst(rst), .bus(b));

  function automatic logic [7:0] obs_a();
    return {a.active, a.fault_latched, a.u_hi, a.u_lo, a.v_hi, a.v_lo, a.w_hi, a.w_lo};
  endfunction

  task automatic push(input int d, input string tag, input logic [7:0] mask, input logic [7:0] val);
    exp_t e;
    e.cyc  = cycle + d;
    e.tag  = tag;
    e.mask = mask;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
        e = sb.pop_front();
        n_assert++;
        if ((obs_a() & e.mask) !== (e.val & e.mask)) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %b expected %b (mask %b)",
                   e.tag, cycle, obs_a() & e.mask, e.val & e.mask, e.mask);
        end
      end
    end
  endtask

  // Overlap on either instance, and on the zero-dead-time instance a gate may only rise after a both-low cycle.
  logic [2:0] prev_hi_b = 3'b000;
  logic [2:0] prev_lo_b = 3'b000;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_assert++;
      if ((({a.w_hi, a.v_hi, a.u_hi} & {a.w_lo, a.v_lo, a.u_lo}) |
           ({b.w_hi, b.v_hi, b.u_hi} & {b.w_lo, b.v_lo, b.u_lo})) !== 3'b000) begin
        n_fail++;
        $display("FAIL overlap @cycle %0d: a hi=%b lo=%b b hi=%b lo=%b required hi&lo=000", cycle,
                 {a.w_hi, a.v_hi, a.u_hi}, {a.w_lo, a.v_lo, a.u_lo}, {b.w_hi, b.v_hi, b.u_hi}, {b.w_lo, b.v_lo, b.u_lo});
      end
      n_assert++;
      if ((((({b.w_hi, b.v_hi, b.u_hi} & ~prev_hi_b) & prev_lo_b) |
            (({b.w_lo, b.v_lo, b.u_lo} & ~prev_lo_b) & prev_hi_b))) !== 3'b000) begin
        n_fail++;
        $display("FAIL no_dead_b @cycle %0d: hi %b->%b lo %b->%b required a both-low cycle", cycle,
                 prev_hi_b, {b.w_hi, b.v_hi, b.u_hi}, prev_lo_b, {b.w_lo, b.v_lo, b.u_lo});
      end
    end
    prev_hi_b = {b.w_hi, b.v_hi, b.u_hi};
    prev_lo_b = {b.w_lo, b.v_lo, b.u_lo};
  end

  task automatic test_reset();
    rst = 1'b1;
    push(2, "reset_state", M_ALL, 8'h00);
    run(3);
    rst = 1'b0;
    push(1, "post_reset_idle", M_ALL, 8'h00);
    push(3, "post_reset_idle", M_ALL, 8'h00);
    run(3);
  endtask

  task automatic test_power_up();
    a.u_in = 1'b0; a.v_in = 1'b1; a.w_in = 1'b0;
    a.enable = 1'b1;
    for (int d = 1; d <= 5; d++) push(d, "power_up_dead", M_ALL, 8'h00);
    push(6, "power_up_on", M_ALL, 8'b1001_1001);
    run(7);
  endtask

  task automatic test_turnaround();
    a.u_in = 1'b1;
    push(1, "turn_lo_hold", M_U_AC, 8'b1001_0000);
    for (int d = 2; d <= 5; d++) push(d, "turn_dead", M_U_AC, 8'b1000_0000);
    push(6, "turn_hi_on", M_U_AC, 8'b1010_0000);
    run(6);
  endtask

  task automatic test_glitch();
    a.u_in = 1'b0;
    push(6, "glitch_setup_low", M_U, 8'b0001_0000);
    run(6);
    a.u_in = 1'b1;
    push(1, "glitch_lo_hold", M_U, 8'b0001_0000);
    for (int d = 2; d <= 9; d++) push(d, "glitch_dead", M_U, 8'h00);
    push(10, "glitch_hi_on", M_U, 8'b0010_0000);
    run(2);
    a.u_in = 1'b0;
    run(2);
    a.u_in = 1'b1;
    run(6);
  endtask

  task automatic test_fault();
    a.fault = 1'b1;
    push(1, "fault_not_yet", M_ALL, 8'b1010_1001);
    push(2, "fault_latched", M_ALL, 8'b1110_1001);
    for (int d = 3; d <= 8; d++) push(d, "fault_off", M_ALL, 8'b0100_0000);
    run(1);
    a.fault = 1'b0;
    run(7);
    a.fault = 1'b1;
    a.clear = 1'b1;
    for (int d = 1; d <= 5; d++) push(d, "clear_blocked", M_ALL, 8'b0100_0000);
    run(1);
    a.fault = 1'b0;
    a.clear = 1'b0;
    run(4);
    a.clear = 1'b1;
    push(1, "clear_pending", M_ALL, 8'b0100_0000);
    for (int d = 2; d <= 6; d++) push(d, "clear_dead", M_ALL, 8'h00);
    push(7, "clear_restart", M_ALL, 8'b1010_1001);
    run(1);
    a.clear = 1'b0;
    run(6);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    n_assert++;
    if (a.u_hi !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre got u_hi=%b required 1", a.u_hi);
    end
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if (obs_a() !== 8'h00) begin
      n_fail++;
      $display("FAIL async_drop got %b required 00000000", obs_a());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int d = 1; d <= 5; d++) push(d, "post_rst_off", M_ALL, 8'h00);
    push(6, "post_rst_on", M_ALL, 8'b1010_1001);
    run(6);
  endtask

  task automatic test_random();
    b.enable = 1'b1; b.u_in = 1'b1; b.v_in = 1'b0; b.w_in = 1'b0;
    b.fault = 1'b0;  b.clear = 1'b0;
    repeat (8) @(negedge clk);
    b.u_in = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({b.u_hi, b.u_lo} !== 2'b10) begin
      n_fail++;
      $display("FAIL dt0_hold got hi/lo=%b required 10", {b.u_hi, b.u_lo});
    end
    @(negedge clk);
    n_assert++;
    if ({b.u_hi, b.u_lo} !== 2'b00) begin
      n_fail++;
      $display("FAIL dt0_dead got hi/lo=%b required 00", {b.u_hi, b.u_lo});
    end
    @(negedge clk);
    n_assert++;
    if ({b.u_hi, b.u_lo} !== 2'b01) begin
      n_fail++;
      $display("FAIL dt0_on got hi/lo=%b required 01", {b.u_hi, b.u_lo});
    end
    for (int i = 0; i < 10000; i++) begin
      b.u_in   = 1'($urandom_range(0, 1));
      b.v_in   = 1'($urandom_range(0, 1));
      b.w_in   = 1'($urandom_range(0, 1));
      b.enable = ($urandom_range(0, 31) != 0);
      b.fault  = ($urandom_range(0, 63) == 0);
      b.clear  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    b.enable = 1'b0;
    b.fault  = 1'b0;
    b.clear  = 1'b0;
    run(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a.enable = 1'b0; a.u_in = 1'b0; a.v_in = 1'b0; a.w_in = 1'b0; a.fault = 1'b0; a.clear = 1'b0;
    b.enable = 1'b0; b.u_in = 1'b0; b.v_in = 1'b0; b.w_in = 1'b0; b.fault = 1'b0; b.clear = 1'b0;
    test_reset();
    test_power_up();
    test_turnaround();
    test_glitch();
    test_fault();
    test_async_reset();
    test_random();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_assert++;
      n_fail++;
      $display("FAIL %s never reached: expected at cycle %0d, run ended at cycle %0d", e.tag, e.cyc, cycle);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
